// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a parameterised UART transmitter
module uart_tx_fifo #(
    parameter int CLK_CYCLES = 4167,
    parameter int CTR_WIDTH  = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         data,
    input  logic               req,
    output logic               ready,
    output logic               uart_tx,
    output logic               busy,
    output logic [FIFO_AW:0]   count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_LAST = CTR_WIDTH'(CLK_CYCLES - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_n;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW:0]     wr_ptr, rd_ptr;
    logic [CTR_WIDTH-1:0] ctr, ctr_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [7:0]           shreg, shreg_n;
    logic                 par_bit, par_bit_n;
    logic                 tx_n;
    logic                 pop, push;
    logic                 bit_end;
    logic [7:0]           head;
    logic                 head_par;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign ready    = (count != (FIFO_AW + 1)'(DEPTH));
    assign busy     = (state != IDLE) || (count != '0);
    assign push     = req && ready;
    assign head     = mem[rd_ptr[FIFO_AW-1:0]];
    assign head_par = (PARITY == 1) ? ~^head : ^head;
    assign bit_end  = (ctr == CTR_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= data & DATA_MASK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ctr     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            uart_tx <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state   <= state_n;
            ctr     <= ctr_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            par_bit <= par_bit_n;
            uart_tx <= tx_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        ctr_n     = ctr;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        tx_n      = uart_tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_n   = START;
                    tx_n      = 1'b0;
                    shreg_n   = head;
                    par_bit_n = head_par;
                    ctr_n     = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    ctr_n     = '0;
                    bit_idx_n = '0;
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                end else begin
                    ctr_n = ctr + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    ctr_n = '0;
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_n = '0;
                        if (PARITY != 0) begin
                            state_n = PAR;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end else begin
                    ctr_n = ctr + 1'b1;
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_n   = STOP;
                    ctr_n     = '0;
                    bit_idx_n = '0;
                    tx_n      = 1'b1;
                end else begin
                    ctr_n = ctr + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    ctr_n = '0;
                    if (bit_idx == STOP_LAST) begin
                        // Chain straight into the next frame when words are waiting.
                        if (count != '0) begin
                            pop       = 1'b1;
                            state_n   = START;
                            tx_n      = 1'b0;
                            shreg_n   = head;
                            par_bit_n = head_par;
                        end else begin
                            state_n = IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        tx_n      = 1'b1;
                    end
                end else begin
                    ctr_n = ctr + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                ctr_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo in 8N1, 7E2 and 8O1 configurations
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_w [3];
    logic       req_w  [3];
    logic       ready_w[3];
    logic       tx_w   [3];
    logic       busy_w [3];
    logic [2:0] count0;
    logic [4:0] count1, count2;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_CYCLES(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)) u_8n1 (
        .clk(clk), .rst(rst), .data(data_w[0]), .req(req_w[0]), .ready(ready_w[0]),
        .uart_tx(tx_w[0]), .busy(busy_w[0]), .count(count0));
    uart_tx_fifo #(.CLK_CYCLES(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_AW(4)) u_7e2 (
        .clk(clk), .rst(rst), .data(data_w[1]), .req(req_w[1]), .ready(ready_w[1]),
        .uart_tx(tx_w[1]), .busy(busy_w[1]), .count(count1));
    uart_tx_fifo #(.CLK_CYCLES(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(4)) u_8o1 (
        .clk(clk), .rst(rst), .data(data_w[2]), .req(req_w[2]), .ready(ready_w[2]),
        .uart_tx(tx_w[2]), .busy(busy_w[2]), .count(count2));

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dbits_of(input int k);
        return (k == 1) ? 7 : 8;
    endfunction

    function automatic int par_of(input int k);
        return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
    endfunction

    function automatic int stops_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int k);
        return 1 + dbits_of(k) + ((par_of(k) != 0) ? 1 : 0) + stops_of(k);
    endfunction

    // Expected line bits, index 0 = start bit; unused upper bits stay 1.
    function automatic logic [15:0] make_frame(input int k, input logic [7:0] d);
        logic [15:0] f;
        int n, ones;
        f = '1;
        f[0] = 1'b0;
        n = 1;
        ones = 0;
        for (int i = 0; i < dbits_of(k); i++) begin
            f[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (par_of(k) == 1) f[n] = ((ones % 2) == 0);
        else if (par_of(k) == 2) f[n] = ((ones % 2) == 1);
        return f;
    endfunction

    function automatic int cnt(input int k);
        case (k)
            0: return int'(count0);
            1: return int'(count1);
            default: return int'(count2);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic exp_push(input int k, input logic [7:0] d);
        case (k)
            0: q0.push_back(make_frame(k, d));
            1: q1.push_back(make_frame(k, d));
            default: q2.push_back(make_frame(k, d));
        endcase
    endtask

    function automatic logic [15:0] exp_pop(input int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int k, input logic [7:0] d);
        data_w[k] = d;
        req_w[k]  = 1'b1;
        @(negedge clk);
        req_w[k]  = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 3000 && busy_w[k]; i++) @(negedge clk);
        chk($sformatf("idle_timeout%0d", k), int'(busy_w[k]), 0);
    endtask

    task automatic mon(input int k);
        logic [15:0] got;
        logic [15:0] exp;
        int bad, len;
        logic aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx_w[k] == 1'b0) begin
                got = '1;
                bad = 0;
                aborted = 1'b0;
                len = frame_len(k);
                for (int b = 0; b < len && !aborted; b++) begin
                    for (int c = 0; c < 4 && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        else if (c == 0) got[b] = tx_w[k];
                        else if (tx_w[k] != got[b]) bad++;
                    end
                end
                if (!aborted) begin
                    chk($sformatf("frame_expected%0d", k), int'(qsize(k) > 0), 1);
                    if (qsize(k) > 0) begin
                        exp = exp_pop(k);
                        chk($sformatf("frame_bits%0d", k), int'(got), int'(exp));
                    end
                    chk($sformatf("bit_hold%0d", k), bad, 0);
                end
            end
        end
    endtask

    task automatic latency_frame(input logic [7:0] d);
        exp_push(0, d);
        push(0, d);
        chk("lat_tx_accept", int'(tx_w[0]), 1);
        chk("lat_count_accept", cnt(0), 1);
        chk("lat_busy_accept", int'(busy_w[0]), 1);
        @(negedge clk);
        chk("lat_start_bit", int'(tx_w[0]), 0);
        chk("lat_count_pop", cnt(0), 0);
        repeat (39) @(negedge clk);
        chk("lat_busy_last_stop", int'(busy_w[0]), 1);
        @(negedge clk);
        chk("lat_busy_done", int'(busy_w[0]), 0);
        chk("lat_tx_idle", int'(tx_w[0]), 1);
    endtask

    initial begin
        int n;
        logic [7:0] r;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_w[k]  = 1'b0;
            data_w[k] = 8'h00;
        end
        fork
            mon(0);
            mon(1);
            mon(2);
        join_none
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_tx%0d", k), int'(tx_w[k]), 1);
            chk($sformatf("rst_ready%0d", k), int'(ready_w[k]), 1);
            chk($sformatf("rst_busy%0d", k), int'(busy_w[k]), 0);
            chk($sformatf("rst_count%0d", k), cnt(k), 0);
        end
        rst = 1'b0;

        latency_frame(8'hA5);

        // Six consecutive writes into a four-deep FIFO: the sixth finds it full.
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("full_ready%0d", i), int'(ready_w[0]), (i < 6) ? 1 : 0);
            if (i < 6) exp_push(0, 8'(i));
            push(0, 8'(i));
        end
        chk("full_count", cnt(0), 4);
        n = 0;
        while (busy_w[0] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_busy_cycles", n, 196);
        chk("b2b_count_end", cnt(0), 0);

        // Push lands on the edge that ends a stop bit while one word waits.
        exp_push(0, 8'h3C);
        push(0, 8'h3C);
        exp_push(0, 8'hC3);
        push(0, 8'hC3);
        chk("pp_count_before", cnt(0), 1);
        repeat (39) @(negedge clk);
        chk("pp_ready", int'(ready_w[0]), 1);
        exp_push(0, 8'h5A);
        push(0, 8'h5A);
        chk("pp_count_after", cnt(0), 1);
        chk("pp_next_start", int'(tx_w[0]), 0);
        wait_idle(0);

        // Reset during data bit 3 with two words queued.
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        chk("mid_count_before", cnt(0), 2);
        repeat (16) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", int'(tx_w[0]), 1);
        chk("mid_rst_count", cnt(0), 0);
        chk("mid_rst_ready", int'(ready_w[0]), 1);
        chk("mid_rst_busy", int'(busy_w[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        latency_frame(8'hA5);

        // 7E2: bit 7 ignored, even parity over seven bits.
        exp_push(1, 8'h83);
        push(1, 8'h83);
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom_range(0, 255));
            exp_push(1, r);
            push(1, r);
        end
        wait_idle(1);

        // 8O1: all-zero and all-one bytes both need parity 1.
        exp_push(2, 8'h00);
        push(2, 8'h00);
        exp_push(2, 8'hFF);
        push(2, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom_range(0, 255));
            exp_push(2, r);
            push(2, r);
        end
        wait_idle(2);

        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom_range(0, 255));
            exp_push(0, r);
            push(0, r);
        end
        wait_idle(0);

        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("queue_drained%0d", k), qsize(k), 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_CYCLES, default 4167, SHALL set the clocks per serial bit period (legal range 2 or more).
REQ-002 Parameter CTR_WIDTH, default 16, SHALL set the bit-period counter width; CLK_CYCLES-1 fits in CTR_WIDTH bits.
REQ-003 Parameter DATA_BITS, default 8, SHALL set the data bits per frame (legal range 5..8).
REQ-004 Parameter PARITY, default 0, SHALL select the parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, SHALL set the stop bits per frame (legal values 1 or 2).
REQ-006 Parameter FIFO_AW, default 4, SHALL set the FIFO depth to 2**FIFO_AW words.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 data  in  8  byte to enqueue; bits above DATA_BITS-1 ignored.
REQ-010 req  in  1  enqueue request, sampled at the rising edge.
REQ-011 ready  out  1  high when the FIFO is not full; a write is accepted when req and ready are both high at an edge.
REQ-012 uart_tx  out  1  registered serial line, idle high.
REQ-013 busy  out  1  high while a frame is on the line or the FIFO is non-empty.
REQ-014 count  out  FIFO_AW+1  number of words currently queued, excluding the frame in flight.

Function
REQ-015 When req is high and ready is low, the block SHALL drop the write; FIFO contents and count SHALL stay unchanged.
REQ-016 The frame SHALL be sent in this order: start bit (0), then DATA_BITS data bits LSB first, then the parity bit if PARITY != 0, then STOP_BITS stop bits (1).
REQ-017 Each frame bit SHALL hold uart_tx for exactly CLK_CYCLES clocks.
REQ-018 The parity bit SHALL be computed over the DATA_BITS data bits only: odd mode makes the total count of ones odd; even mode makes it even.
REQ-019 The FSM SHALL have the states IDLE, START, DATA, PAR, STOP.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop the head word into a shift register, drive uart_tx to 0 and enter START on the same edge.
REQ-021 A write into an empty FIFO while the FSM is in IDLE SHALL produce the start bit on uart_tx one edge after the accepting edge.
REQ-022 START SHALL go to DATA; after the last data bit the FSM SHALL go to PAR if parity is enabled, otherwise to STOP; PAR SHALL go to STOP.
REQ-023 At the end of the last stop bit, if the FIFO is non-empty the FSM SHALL pop and enter START on that same edge, giving back-to-back frames with no idle gap.
REQ-024 At the end of the last stop bit, if the FIFO is empty the FSM SHALL enter IDLE with uart_tx at 1.
REQ-025 A push and a pop on the same edge SHALL both take effect; count SHALL stay unchanged and pointers SHALL wrap modulo 2**FIFO_AW.
REQ-026 A push on the same edge that a full FIFO pops SHALL be refused, because ready reflects the pre-edge state.
REQ-027 ready, busy and count SHALL be derived from registered state only, with no combinational path from req or data.
REQ-028 The bit-period counter SHALL restart at 0 on every bit transition and SHALL not free-run in IDLE.

Reset
REQ-029 While rst is high, the block SHALL force uart_tx=1, ready=1, busy=0, count=0, state IDLE, FIFO pointers 0 and bit counter 0, asynchronously and without waiting for a clock edge.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately and discard all queued words.
REQ-031 After rst deasserts, the first accepted write SHALL behave per REQ-021.

Verification
REQ-032 Frame timing (CLK_CYCLES=4, 8N1): write 0xA5 into an empty FIFO -> uart_tx reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks, with the start bit one edge after the accepting edge; busy=0 after the stop bit.
REQ-033 Parity and width (DATA_BITS=7, PARITY=2, STOP_BITS=2): write 0x83 -> uart_tx reads 0, 1,1,0,0,0,0,0, parity 0, 1,1; bit 7 of the input is ignored.
REQ-034 Odd parity (DATA_BITS=8, PARITY=1): write 0x00 -> parity bit 1; write 0xFF -> parity bit 1.
REQ-035 Back-to-back and full (FIFO_AW=2): 6 consecutive writes 0x01..0x06 -> the first is popped at once, the next 4 fill the FIFO, and ready drops so the 6th is dropped; frames 0x01..0x05 go out with no idle cycles between them and count returns to 0.
REQ-036 Simultaneous push/pop: write on the exact edge where a stop bit ends with count=1 -> count stays 1 and the next frame starts on that edge.
REQ-037 Reset mid-frame: assert rst during data bit 3 with count=2 -> uart_tx=1 with no clock edge, count=0, ready=1; after release, a new write gives a clean frame per REQ-032.
